// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester (master) and the register-file completer.
// When APB_SLAVE_PSTRB_EN is defined the bundle also carries the APB4 byte strobes.
interface apb_slave_regfile_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSELx;
    logic        PENABLE;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]  PSTRB;
`endif
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
`ifdef APB_SLAVE_PSTRB_EN
        output PSTRB,
`endif
        output PADDR, PWRITE, PWDATA, PSELx, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
`ifdef APB_SLAVE_PSTRB_EN
        input  PSTRB,
`endif
        input  PADDR, PWRITE, PWDATA, PSELx, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB3 completer backed by NUM_REGS 32-bit read/write registers starting at BASE_ADDR.
// Every access phase is stretched by WAIT_STATES cycles. Out-of-window or misaligned
// addresses complete with PSLVERR and have no effect.
// Optional feature macro: APB_SLAVE_PSTRB_EN adds APB4 byte strobes (PSTRB) to writes.
module apb_slave_regfile #(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input logic                i_clk,
    input logic                i_reset,
    apb_slave_regfile_if.slave bus
);
    localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_nx;
    logic [3:0]        wcnt, wcnt_nx;
    logic              setup_fire;
    logic              commit;
    logic              ready;

    logic              err_d;
    logic [IDX_W-1:0]  idx_d;

    logic              write_l;
    logic              err_l;
    logic [IDX_W-1:0]  idx_l;
    logic [31:0]       wdata_l;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]        strb_l;
`endif
    logic [31:0]       wr_value;
    logic [31:0]       regs [NUM_REGS];

    // Address decode of the setup-phase address; the 33-bit compare avoids wrap at the top of memory.
    always_comb begin
        err_d = (bus.PADDR[1:0] != 2'b00)
             || (bus.PADDR < BASE_ADDR)
             || ({1'b0, bus.PADDR} >= END_ADDR);
        idx_d = IDX_W'((bus.PADDR - BASE_ADDR) >> 2);
    end

    // Next-state logic: an abort (select or enable dropped) wins over completion so it never writes.
    always_comb begin
        state_nx   = state;
        wcnt_nx    = wcnt;
        setup_fire = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.PSELx && !bus.PENABLE) begin
                    setup_fire = 1'b1;
                    wcnt_nx    = WAIT_INIT;
                    state_nx   = ACCESS;
                end
            end
            ACCESS: begin
                if (!(bus.PSELx && bus.PENABLE)) begin
                    state_nx = IDLE;
                    wcnt_nx  = 4'd0;
                end else if (wcnt == 4'd0) begin
                    commit   = write_l && !err_l;
                    state_nx = IDLE;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                wcnt_nx  = 4'd0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Transfer attributes captured in the setup phase; only meaningful while in ACCESS.
    always_ff @(posedge i_clk) begin
        if (setup_fire) begin
            write_l <= bus.PWRITE;
            err_l   <= err_d;
            idx_l   <= idx_d;
            wdata_l <= bus.PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
            strb_l  <= bus.PSTRB;
`endif
        end
    end

    // Value written on commit: full word, or a byte-wise merge with the current contents.
    always_comb begin
        wr_value = wdata_l;
`ifdef APB_SLAVE_PSTRB_EN
        for (int b = 0; b < 4; b++) begin
            wr_value[8*b +: 8] = strb_l[b] ? wdata_l[8*b +: 8] : regs[idx_l][8*b +: 8];
        end
`endif
    end

    // Register bank; reset restores every word, which also cancels a write pending at that edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (commit) begin
            regs[idx_l] <= wr_value;
        end
    end

    // Responses come purely from registered state so PREADY has no path from the bus inputs.
    assign ready       = (state == ACCESS) && (wcnt == 4'd0);
    assign bus.PREADY  = ready;
    assign bus.PSLVERR = ready && err_l;
    assign bus.PRDATA  = (ready && !write_l && !err_l) ? regs[idx_l] : 32'h0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a WAIT_STATES=2 instance for most traffic and a
// WAIT_STATES=0 instance for the zero-wait back-to-back case. Strobe tests run only when
// APB_SLAVE_PSTRB_EN is defined.
module tb_apb_slave_regfile;
    logic i_clk = 1'b0;
    logic i_reset;
    int   checks = 0;
    int   passed = 0;

    apb_slave_regfile_if b0 ();
    apb_slave_regfile_if b1 ();

    apb_slave_regfile #(.WAIT_STATES(2)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (b0.slave)
    );

    apb_slave_regfile #(.WAIT_STATES(0)) dut_z (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (b1.slave)
    );

    always #5 i_clk = ~i_clk;

`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0] strb_drv = 4'hF;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete transfer on the WAIT_STATES=2 instance; checks the wait count and
    // returns the response sampled in the PREADY cycle, then idles the bus.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata, output logic err);
        int waits;
        @(negedge i_clk);
        b0.PSELx   = 1'b1;
        b0.PENABLE = 1'b0;
        b0.PADDR   = addr;
        b0.PWRITE  = wr;
        b0.PWDATA  = data;
`ifdef APB_SLAVE_PSTRB_EN
        b0.PSTRB   = strb_drv;
`endif
        @(negedge i_clk);
        b0.PENABLE = 1'b1;
        waits = 0;
        while (!b0.PREADY && waits < 20) begin
            @(negedge i_clk);
            waits++;
        end
        check({tag, "_waits"}, 32'(waits), 32'd2);
        rdata = b0.PRDATA;
        err   = b0.PSLVERR;
        @(negedge i_clk);
        b0.PSELx   = 1'b0;
        b0.PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_regs [8];
        logic [31:0] bad_addr [3];

        bad_addr[0] = 32'h0000_1020;
        bad_addr[1] = 32'h0000_0FFC;
        bad_addr[2] = 32'h0000_1002;

        i_reset    = 1'b1;
        b0.PSELx   = 1'b0;
        b0.PENABLE = 1'b0;
        b0.PADDR   = 32'h0;
        b0.PWRITE  = 1'b0;
        b0.PWDATA  = 32'h0;
        b1.PSELx   = 1'b0;
        b1.PENABLE = 1'b0;
        b1.PADDR   = 32'h0;
        b1.PWRITE  = 1'b0;
        b1.PWDATA  = 32'h0;
`ifdef APB_SLAVE_PSTRB_EN
        b0.PSTRB   = 4'hF;
        b1.PSTRB   = 4'hF;
`endif
        repeat (3) @(negedge i_clk);
        check("rst_pready",  {31'h0, b0.PREADY},  32'h0);
        check("rst_prdata",  b0.PRDATA,           32'h0);
        check("rst_pslverr", {31'h0, b0.PSLVERR}, 32'h0);
        i_reset = 1'b0;

        // Basic read of a freshly reset register.
        xfer("rd1000", 1'b0, 32'h1000, 32'h0, rd, er);
        check("rd1000_data", rd, 32'h0);
        check("rd1000_err", {31'h0, er}, 32'h0);

        // Write/read round trips at both ends of the window.
        xfer("wr1000", 1'b1, 32'h1000, 32'hDEADBEEF, rd, er);
        check("wr1000_err", {31'h0, er}, 32'h0);
        xfer("rd1000b", 1'b0, 32'h1000, 32'h0, rd, er);
        check("rd1000b_data", rd, 32'hDEADBEEF);
        check("rd1000b_err", {31'h0, er}, 32'h0);
        xfer("wr101c", 1'b1, 32'h101C, 32'h12345678, rd, er);
        xfer("rd101c", 1'b0, 32'h101C, 32'h0, rd, er);
        check("rd101c_data", rd, 32'h12345678);
        xfer("rd1000c", 1'b0, 32'h1000, 32'h0, rd, er);
        check("rd1000c_data", rd, 32'hDEADBEEF);

        // Out-of-window and misaligned accesses error out and change nothing.
        for (int k = 0; k < 3; k++) begin
            xfer($sformatf("badwr%0d", k), 1'b1, bad_addr[k], 32'hFFFFFFFF, rd, er);
            check($sformatf("badwr%0d_err", k), {31'h0, er}, 32'h1);
            xfer($sformatf("badrd%0d", k), 1'b0, bad_addr[k], 32'h0, rd, er);
            check($sformatf("badrd%0d_err", k), {31'h0, er}, 32'h1);
            check($sformatf("badrd%0d_data", k), rd, 32'h0);
        end
        for (int k = 0; k < 8; k++) exp_regs[k] = 32'h0;
        exp_regs[0] = 32'hDEADBEEF;
        exp_regs[7] = 32'h12345678;
        for (int k = 0; k < 8; k++) begin
            xfer($sformatf("scan%0d", k), 1'b0, 32'h1000 + 32'(4 * k), 32'h0, rd, er);
            check($sformatf("scan%0d_data", k), rd, exp_regs[k]);
        end

        // Abort: select dropped in the second wait cycle.
        @(negedge i_clk);
        b0.PSELx   = 1'b1;
        b0.PENABLE = 1'b0;
        b0.PADDR   = 32'h1008;
        b0.PWRITE  = 1'b1;
        b0.PWDATA  = 32'h55;
        @(negedge i_clk);
        b0.PENABLE = 1'b1;
        check("abort_w1_pready", {31'h0, b0.PREADY}, 32'h0);
        @(negedge i_clk);
        check("abort_w2_pready", {31'h0, b0.PREADY}, 32'h0);
        b0.PSELx   = 1'b0;
        b0.PENABLE = 1'b0;
        @(negedge i_clk);
        check("abort_after1_pready", {31'h0, b0.PREADY}, 32'h0);
        @(negedge i_clk);
        check("abort_after2_pready", {31'h0, b0.PREADY}, 32'h0);
        xfer("rd1008", 1'b0, 32'h1008, 32'h0, rd, er);
        check("rd1008_data", rd, 32'h0);

        // Zero-wait instance: write then read back-to-back in four cycles.
        @(negedge i_clk);
        b1.PSELx   = 1'b1;
        b1.PENABLE = 1'b0;
        b1.PADDR   = 32'h1004;
        b1.PWRITE  = 1'b1;
        b1.PWDATA  = 32'hA5A5A5A5;
        check("z_setup1_pready", {31'h0, b1.PREADY}, 32'h0);
        @(negedge i_clk);
        b1.PENABLE = 1'b1;
        check("z_acc1_pready", {31'h0, b1.PREADY}, 32'h1);
        check("z_acc1_err", {31'h0, b1.PSLVERR}, 32'h0);
        @(negedge i_clk);
        b1.PENABLE = 1'b0;
        b1.PWRITE  = 1'b0;
        check("z_setup2_pready", {31'h0, b1.PREADY}, 32'h0);
        @(negedge i_clk);
        b1.PENABLE = 1'b1;
        check("z_acc2_pready", {31'h0, b1.PREADY}, 32'h1);
        check("z_acc2_data", b1.PRDATA, 32'hA5A5A5A5);
        @(negedge i_clk);
        b1.PSELx   = 1'b0;
        b1.PENABLE = 1'b0;

        // Reset arrives on the completing edge of a pending write.
        @(negedge i_clk);
        b0.PSELx   = 1'b1;
        b0.PENABLE = 1'b0;
        b0.PADDR   = 32'h100C;
        b0.PWRITE  = 1'b1;
        b0.PWDATA  = 32'h77;
        @(negedge i_clk);
        b0.PENABLE = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check("rstw_pready_before", {31'h0, b0.PREADY}, 32'h1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rstw_pready", {31'h0, b0.PREADY}, 32'h0);
        check("rstw_prdata", b0.PRDATA, 32'h0);
        check("rstw_pslverr", {31'h0, b0.PSLVERR}, 32'h0);
        i_reset    = 1'b0;
        b0.PSELx   = 1'b0;
        b0.PENABLE = 1'b0;
        xfer("rd100c", 1'b0, 32'h100C, 32'h0, rd, er);
        check("rd100c_data", rd, 32'h0);
        xfer("rd1000r", 1'b0, 32'h1000, 32'h0, rd, er);
        check("rd1000r_data", rd, 32'h0);

`ifdef APB_SLAVE_PSTRB_EN
        // Byte strobes: only strobed bytes change; an all-zero strobe is a harmless no-op.
        strb_drv = 4'b0101;
        xfer("strb_wr", 1'b1, 32'h1010, 32'hFFFFFFFF, rd, er);
        check("strb_wr_err", {31'h0, er}, 32'h0);
        strb_drv = 4'b0000;
        xfer("strb_rd", 1'b0, 32'h1010, 32'h0, rd, er);
        check("strb_rd_data", rd, 32'h00FF00FF);
        xfer("strb0_wr", 1'b1, 32'h1010, 32'h12345678, rd, er);
        check("strb0_wr_err", {31'h0, er}, 32'h0);
        xfer("strb0_rd", 1'b0, 32'h1010, 32'h0, rd, er);
        check("strb0_rd_data", rd, 32'h00FF00FF);
        strb_drv = 4'hF;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
